// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM states, the one-hot PC-source
// encoding the decoder drives, and a select sanity helper.
package pc_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_UPDATE,
      ST_HALTED
   } seq_state_t;

   // Bit order matches {sel_PCSrc_const, sel_PCSrc_offset, sel_PCSrc_plus1}.
   typedef enum logic [2:0] {
      PC_SRC_PLUS1  = 3'b001,
      PC_SRC_OFFSET = 3'b010,
      PC_SRC_CONST  = 3'b100
   } pc_src_t;

   function automatic logic pc_src_onehot(input logic [2:0] sel);
      return (sel == PC_SRC_PLUS1) || (sel == PC_SRC_OFFSET) || (sel == PC_SRC_CONST);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch bus plus decoder/datapath handshake seen by the PC sequencer.
// master = sequencer side, slave = memory/decoder side.
interface pc_sequencer_if #(
   parameter int PC_WIDTH     = 12,
   parameter int INSTR_WIDTH  = 19,
   parameter int OFFSET_WIDTH = 8
);
   logic                    imem_req;
   logic [PC_WIDTH-1:0]     imem_addr;
   logic                    imem_ack;
   logic [INSTR_WIDTH-1:0]  imem_data;
   logic [INSTR_WIDTH-1:0]  instr;
   logic                    instr_valid;
   logic                    exec_done;
   logic                    sel_PCSrc_plus1;
   logic                    sel_PCSrc_offset;
   logic                    sel_PCSrc_const;
   logic                    branch_taken;
   logic [OFFSET_WIDTH-1:0] jump_offset;
   logic [PC_WIDTH-1:0]     jump_const;

   modport master (
      output imem_req, imem_addr, instr, instr_valid,
      input  imem_ack, imem_data, exec_done,
      input  sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const,
      input  branch_taken, jump_offset, jump_const
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid,
      output imem_ack, imem_data, exec_done,
      output sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const,
      output branch_taken, jump_offset, jump_const
   );
endinterface

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC selection; flags select vectors that are not one-hot.
// All arithmetic wraps modulo 2^PC_WIDTH.
module pc_next_calc
   import pc_sequencer_pkg::*;
#(
   parameter int PC_WIDTH     = 12,
   parameter int OFFSET_WIDTH = 8
) (
   input  logic [PC_WIDTH-1:0]     pc,
   input  logic [2:0]              sel,
   input  logic                    branch_taken,
   input  logic [OFFSET_WIDTH-1:0] jump_offset,
   input  logic [PC_WIDTH-1:0]     jump_const,
   output logic [PC_WIDTH-1:0]     next_pc,
   output logic                    sel_error
);

   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] off_ext;
   logic [PC_WIDTH-1:0] pc_rel;

   assign off_ext = {{(PC_WIDTH-OFFSET_WIDTH){jump_offset[OFFSET_WIDTH-1]}}, jump_offset};
   assign pc_inc  = pc + PC_WIDTH'(1);
   assign pc_rel  = pc + off_ext;

   assign sel_error = !pc_src_onehot(sel);

   // Bad selects fall through to the default and advance sequentially.
   always_comb begin
      next_pc = pc_inc;
      case (sel)
         PC_SRC_OFFSET: next_pc = branch_taken ? pc_rel : pc_inc;
         PC_SRC_CONST:  next_pc = jump_const;
         default:       next_pc = pc_inc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: IDLE -> FETCH -> ISSUE -> UPDATE loop,
// with latched halt and a sticky bad-select flag.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int                  PC_WIDTH     = 12,
   parameter int                  INSTR_WIDTH  = 19,
   parameter int                  OFFSET_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                halt,
   pc_sequencer_if.master      bus,
   output logic [PC_WIDTH-1:0] pc,
   output logic                sel_error,
   output logic                busy
);

   seq_state_t             state;
   logic                   req_q;
   logic                   valid_q;
   logic                   halt_q;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic [PC_WIDTH-1:0]    pc_next_q;
   logic [PC_WIDTH-1:0]    calc_pc;
   logic                   calc_err;

   pc_next_calc #(
      .PC_WIDTH     (PC_WIDTH),
      .OFFSET_WIDTH (OFFSET_WIDTH)
   ) u_next (
      .pc           (pc),
      .sel          ({bus.sel_PCSrc_const, bus.sel_PCSrc_offset, bus.sel_PCSrc_plus1}),
      .branch_taken (bus.branch_taken),
      .jump_offset  (bus.jump_offset),
      .jump_const   (bus.jump_const),
      .next_pc      (calc_pc),
      .sel_error    (calc_err)
   );

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pc        <= RESET_PC;
         pc_next_q <= RESET_PC;
         instr_q   <= '0;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
         halt_q    <= 1'b0;
         sel_error <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
                  req_q <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (bus.imem_ack) begin
                  instr_q <= bus.imem_data;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  halt_q  <= 1'b0;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (halt) halt_q <= 1'b1;
               // Selects are only meaningful in the exec_done cycle.
               if (bus.exec_done) begin
                  pc_next_q <= calc_pc;
                  if (calc_err) sel_error <= 1'b1;
                  valid_q   <= 1'b0;
                  state     <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               pc <= pc_next_q;
               if (halt_q || halt) begin
                  state <= ST_HALTED;
                  busy  <= 1'b0;
               end else begin
                  state <= ST_FETCH;
                  req_q <= 1'b1;
               end
            end
            ST_HALTED: ;
            default: begin
               state <= ST_IDLE;
               req_q <= 1'b0;
               valid_q <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed corner cases then randomized instruction
// stream, checked against a transaction-level next-PC model.
module tb_pc_sequencer;
   localparam int PW  = 12;
   localparam int IW  = 19;
   localparam int OW  = 8;
   localparam int MOD = 1 << PW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          halt;
   logic [PW-1:0] pc;
   logic          sel_error;
   logic          busy;

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;
   int exp_pc;
   bit exp_err;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pc_sequencer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .OFFSET_WIDTH(OW)) bus ();

   pc_sequencer #(
      .PC_WIDTH(PW), .INSTR_WIDTH(IW), .OFFSET_WIDTH(OW), .RESET_PC(12'd0)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .bus(bus),
      .pc(pc), .sel_error(sel_error), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: count the selects, then apply the rule as plain integer math.
   function automatic int ref_next(input int p, input bit p1, input bit of, input bit cn,
                                   input bit tk, input int off8, input int jc, output bit bad);
      int n;
      int o;
      n   = int'(p1) + int'(of) + int'(cn);
      bad = (n != 1);
      if (bad || p1) return (p + 1) % MOD;
      if (cn) return jc;
      o = (off8 >= (1 << (OW - 1))) ? off8 - (1 << OW) : off8;
      return tk ? (p + o + MOD) % MOD : (p + 1) % MOD;
   endfunction

   task automatic junk_sel();
      bus.sel_PCSrc_plus1  = 1'($urandom);
      bus.sel_PCSrc_offset = 1'($urandom);
      bus.sel_PCSrc_const  = 1'($urandom);
      bus.branch_taken     = 1'($urandom);
      bus.jump_offset      = OW'($urandom);
      bus.jump_const       = PW'($urandom);
   endtask

   task automatic idle_inputs();
      start = 1'b0;
      halt  = 1'b0;
      bus.imem_ack  = 1'b0;
      bus.imem_data = '0;
      bus.exec_done = 1'b0;
      junk_sel();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      check("rst_pc", pc, 0);
      check("rst_req", bus.imem_req, 0);
      check("rst_valid", bus.instr_valid, 0);
      check("rst_instr", bus.instr, 0);
      check("rst_sel_error", sel_error, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      exp_pc  = 0;
      exp_err = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs one instruction; entered at a negedge with the DUT in (or about to be in) FETCH.
   task automatic run_instr(input int ack_dly, input int exec_dly, input logic [IW-1:0] data,
                            input bit p1, input bit of, input bit cn, input bit tk,
                            input logic [OW-1:0] off, input logic [PW-1:0] jc, input bit hlt);
      int n;
      int t0;
      int np;
      bit bad;
      n = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.imem_req !== 1'b1) begin
         check("fetch_timeout", 0, 1);
         return;
      end
      t0 = cyc;
      check("fetch_addr", bus.imem_addr, exp_pc);
      check("pc_in_fetch", pc, exp_pc);
      check("busy_fetch", busy, 1);
      repeat (ack_dly) begin
         @(negedge clk);
         check("req_held", {bus.imem_req, bus.imem_addr}, {1'b1, PW'(exp_pc)});
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = data;
      @(negedge clk);
      bus.imem_ack  = 1'b0;
      bus.imem_data = IW'($urandom);
      check("issue_valid", bus.instr_valid, 1);
      check("issue_instr", bus.instr, data);
      check("issue_req_low", bus.imem_req, 0);
      if (hlt) halt = 1'b1;
      repeat (exec_dly) begin
         @(negedge clk);
         halt = 1'b0;
         junk_sel();
         check("issue_hold", {bus.instr_valid, bus.instr}, {1'b1, data});
      end
      bus.exec_done        = 1'b1;
      bus.sel_PCSrc_plus1  = p1;
      bus.sel_PCSrc_offset = of;
      bus.sel_PCSrc_const  = cn;
      bus.branch_taken     = tk;
      bus.jump_offset      = off;
      bus.jump_const       = jc;
      @(negedge clk);
      halt          = 1'b0;
      bus.exec_done = 1'b0;
      junk_sel();
      np = ref_next(exp_pc, p1, of, cn, tk, int'(off), int'(jc), bad);
      exp_err = exp_err | bad;
      check("update_valid_low", bus.instr_valid, 0);
      check("update_pc_hold", pc, exp_pc);
      check("update_busy", busy, 1);
      @(negedge clk);
      exp_pc = np;
      check("pc_next", pc, exp_pc);
      check("sel_error", sel_error, exp_err);
      if (hlt) begin
         check("halted_req", bus.imem_req, 0);
         check("halted_busy", busy, 0);
      end else begin
         check("next_req", bus.imem_req, 1);
         check("next_addr", bus.imem_addr, exp_pc);
         check("period", cyc - t0, ack_dly + exec_dly + 3);
      end
   endtask

   task automatic jump_to(input int target);
      run_instr(0, 0, IW'($urandom), 0, 0, 1, 0, '0, PW'(target), 0);
   endtask

   initial begin
      int r;
      bit p1, of, cn;
      rst = 1'b1;
      idle_inputs();
      exp_pc  = 0;
      exp_err = 1'b0;
      do_reset();
      @(negedge clk);
      check("idle_no_req", bus.imem_req, 0);

      // Straight line, 2-cycle ack wait: 5-cycle period
      do_start();
      for (int i = 0; i < 5; i++) run_instr(2, 0, IW'($urandom), 1, 0, 0, 0, '0, '0, 0);

      // Async reset while fetching pc=5
      check("pre_rst_addr", bus.imem_addr, 5);
      #2 rst = 1'b1;
      #1;
      check("async_rst_req", bus.imem_req, 0);
      check("async_rst_pc", pc, 0);
      check("async_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_pc  = 0;
      exp_err = 1'b0;
      @(negedge clk);
      check("post_rst_idle", bus.imem_req, 0);
      do_start();

      // Offset jumps from pc=10 by -3
      jump_to(10);
      run_instr(1, 1, IW'($urandom), 0, 1, 0, 1, 8'hFD, '0, 0);
      check("offset_taken", exp_pc, 7);
      jump_to(10);
      run_instr(0, 2, IW'($urandom), 0, 1, 0, 0, 8'hFD, '0, 0);

      // Wrap corners at pc=4095
      jump_to(4095);
      run_instr(0, 0, IW'($urandom), 0, 0, 1, 0, '0, 12'h123, 0);
      jump_to(4095);
      run_instr(0, 0, IW'($urandom), 1, 0, 0, 0, '0, '0, 0);

      // Bad select at pc=20, then confirm stickiness
      jump_to(20);
      run_instr(0, 0, IW'($urandom), 1, 0, 1, 0, '0, 12'h555, 0);
      run_instr(0, 0, IW'($urandom), 1, 0, 0, 0, '0, '0, 0);

      // Random stream
      do_reset();
      do_start();
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 7);
         if (r == 0) begin
            p1 = 1'($urandom); of = 1'($urandom); cn = 1'($urandom);
         end else begin
            r  = $urandom_range(0, 2);
            p1 = (r == 0); of = (r == 1); cn = (r == 2);
         end
         run_instr($urandom_range(0, 3), $urandom_range(0, 3), IW'($urandom),
                   p1, of, cn, 1'($urandom), OW'($urandom), PW'($urandom), 0);
      end

      // Halt during ISSUE at pc=6
      jump_to(6);
      run_instr(0, 1, IW'($urandom), 1, 0, 0, 0, '0, '0, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("halted_ignores_start", {bus.imem_req, busy, pc}, {1'b0, 1'b0, 12'd7});
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout got=%0d exp=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and fetch sequencer. It is the consumer end of the PC-source select lines that the instruction decoder drives.
- Holds the PC and fetches one instruction from instruction memory over a req/ack handshake.
- Presents the instruction to the decoder/datapath and waits for execution to complete.
- Updates the PC from whichever of plus1 / offset / const the decoder selected.

Parameters:
PC_WIDTH, 12, PC and instruction-memory address width
INSTR_WIDTH, 19, instruction word width
OFFSET_WIDTH, 8, signed conditional-jump offset width
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  leave IDLE and begin fetching at current PC
halt  input  1  stop after current instruction completes
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_WIDTH  fetch address (equals pc while imem_req=1)
imem_ack  input  1  memory has data valid on imem_data this cycle
imem_data  input  INSTR_WIDTH  fetched instruction word
instr  output  INSTR_WIDTH  instruction register to decoder/datapath
instr_valid  output  1  instr is live; decoder selects are sampled while high
exec_done  input  1  datapath finished current instruction
sel_PCSrc_plus1  input  1  next PC = PC+1
sel_PCSrc_offset  input  1  conditional jump, PC-relative
sel_PCSrc_const  input  1  unconditional jump, absolute
branch_taken  input  1  condition result for offset jump
jump_offset  input  OFFSET_WIDTH  signed offset, two's complement
jump_const  input  PC_WIDTH  absolute jump target
pc  output  PC_WIDTH  current PC
sel_error  output  1  sticky: selects were not one-hot at update
busy  output  1  high in FETCH, ISSUE, UPDATE

Behaviour:
Reset (asynchronous, active-high):
- pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, sel_error=0, busy=0, state=IDLE.
- Reset asserted mid-fetch or mid-issue drops imem_req and instr_valid immediately; no PC update occurs.

States:
- IDLE: outputs quiescent. start=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. On imem_ack, instr<=imem_data -> ISSUE. Ack in the same cycle req rises is legal, giving 1-cycle fetch. No timeout.
- ISSUE: instr_valid=1. Decoder selects and jump inputs are sampled in the cycle exec_done=1; that cycle moves to UPDATE. instr is held constant throughout ISSUE.
- UPDATE (1 cycle): pc <= next_pc, instr_valid=0. halt (sampled any cycle since entering ISSUE, latched) -> HALTED, else -> FETCH.
- HALTED: imem_req=0, busy=0. Only reset exits. start is ignored.

Next-PC rules (sampled with exec_done):
- plus1 only: pc+1.
- offset only: pc + sign_extend(jump_offset) if branch_taken, else pc+1.
- const only: jump_const.
- All arithmetic is modulo 2^PC_WIDTH; wrap is silent (4095+1=0; 2 + (-4) = 4094).
- Zero or more than one select high: set sel_error (sticky until reset); next pc = pc+1.

Latency:
- Minimum instruction period is 3 cycles: FETCH with immediate ack, ISSUE with immediate exec_done, UPDATE.
- pc output changes only on the clock edge leaving UPDATE.

Decomposition:
- Shared package: state enum (IDLE, FETCH, ISSUE, UPDATE, HALTED) and a pc_src one-hot typedef {PLUS1, OFFSET, CONST}, kept beside the existing opcode defines.
- One natural sub-module, pc_next_calc: combinational next-PC and sel_error detection, so it can be unit-tested separately.
- FSM and registers stay in pc_sequencer.

Test Plan:
- Reset mid-FETCH with pc=5 -> imem_req drops the same cycle, pc=0, state IDLE; start -> imem_addr=0.
- Straight line: start, ack every fetch after 2 cycles, plus1, exec_done immediate -> imem_addr sequence 0,1,2,3; each instruction takes 5 cycles.
- Offset jump at pc=10, jump_offset=-3: branch_taken=1 -> next fetch addr 7; branch_taken=0 -> addr 11.
- Const jump at pc=4095 with jump_const=0x123 -> next fetch 0x123. plus1 at pc=4095 -> next fetch 0, no error.
- Selects {plus1, const} both high at pc=20 -> sel_error=1 and stays 1; next fetch addr 21.
- halt pulsed during ISSUE at pc=6 -> UPDATE sets pc=7, then HALTED with imem_req=0 and busy=0; later start is ignored.
